g1_input_debounce: RTL and testbench
====================================

G1_INPUT_DEBOUNCE -- requirements
Module: g1_input_debounce

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 16: consecutive synchronized-mismatch cycles required before a bit of x_out updates; legal range 2..65535.
REQ-002 SHALL provide port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide port sw_in  input  4  raw asynchronous switch levels, bit i independent.
REQ-005 SHALL provide port hold  input  1  synchronous freeze of debounce decisions.
REQ-006 SHALL provide port x_out  output  4  debounced, registered value feeding the downstream g1 logic stage x[3:0].
REQ-007 SHALL provide port x_changed  output  1  one-cycle pulse, high in the first cycle a new x_out value is visible.
REQ-008 SHALL provide port busy  output  1  high when any per-bit counter is nonzero.

Function
REQ-009 SHALL pass each sw_in bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-010 SHALL keep one counter per bit, width clog2(STABLE_CYCLES+1), unsigned, never wrapping.
REQ-011 SHALL, per bit with hold=0: if sync2[i]==x_out[i], clear counter[i] to 0.
REQ-012 SHALL, per bit with hold=0: if sync2[i]!=x_out[i] and counter[i]<STABLE_CYCLES-1, increment counter[i].
REQ-013 SHALL, per bit with hold=0: if sync2[i]!=x_out[i] and counter[i]==STABLE_CYCLES-1, load x_out[i]<=sync2[i] and clear counter[i] to 0 on the same edge.
REQ-014 SHALL give latency: sw_in[i] changed and stable before edge 0 -> new x_out[i] visible after edge STABLE_CYCLES+1; no earlier, no later.
REQ-015 SHALL discard any mismatch run shorter than STABLE_CYCLES edges (glitch): counter returns to 0, x_out[i] unchanged.
REQ-016 SHALL treat the four bits fully independently; bits whose runs complete on the same edge update together.
REQ-017 SHALL assert x_changed for exactly one cycle after any edge on which at least one x_out bit updates; simultaneous bit updates produce one pulse.
REQ-018 SHALL, while hold=1, keep x_out unchanged, force all counters to 0, keep x_changed=0; synchronizer keeps sampling.
REQ-019 SHALL, after hold deasserts, require a full fresh run of STABLE_CYCLES mismatch edges before any update.
REQ-020 SHALL drive busy combinationally from counters (OR of counter[i]!=0).
REQ-021 SHALL contain no combinational path from sw_in or hold to x_out or x_changed.

Reset
REQ-022 SHALL, on rst_n=0, immediately clear sync1, sync2, all counters, x_out (4'h0), x_changed (0); busy reads 0.
REQ-023 SHALL hold all state at reset values while rst_n=0, regardless of clk, sw_in, hold.
REQ-024 SHALL, when rst_n asserts mid-count, abandon the run; after release, counting restarts from 0 with latency per REQ-014 measured from the first edge after release.

Verification (STABLE_CYCLES=4)
REQ-025 SHALL cover: reset with sw_in=4'hF, release before edge 0 -> x_out=0 through edge 4, x_out=4'hF after edge 5, x_changed high one cycle only.
REQ-026 SHALL cover: x_out=0, sw_in[0] high for exactly 3 cycles then low -> x_out stays 4'h0, x_changed never asserts, busy returns to 0.
REQ-027 SHALL cover: sw_in[0] high for exactly 4 cycles, stable -> x_out=4'h1 after edge 5; sw_in[3] rising 2 cycles later -> x_out=4'h9 two cycles after that; two separate x_changed pulses.
REQ-028 SHALL cover: sw_in 4'h0->4'h6 with hold=1 for 10 cycles -> x_out stays 4'h0, busy=0; hold drops before edge N -> x_out=4'h6 after edge N+3, one pulse.
REQ-029 SHALL cover: counter[2] at 2 mid-run, rst_n pulsed low between edges -> x_out, counters, x_changed 0 immediately; update re-timed per REQ-024.
REQ-030 SHALL cover: all four bits 0->1 on the same cycle -> x_out 4'h0->4'hF on one edge, exactly one x_changed pulse.

Source files
------------

// File: rtl/g1_input_debounce_if.sv
//----------------------------------------------------------------------------
// Module  : g1_input_debounce_if
// Brief   : Switch-input / debounced-output bundle for g1_input_debounce.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface g1_input_debounce_if;
    logic [3:0] sw_in;
    logic       hold;
    logic [3:0] x_out;
    logic       x_changed;
    logic       busy;

    // master drives raw switches and hold; slave is the debouncer
    modport master (
        output sw_in,
        output hold,
        input  x_out,
        input  x_changed,
        input  busy
    );

    modport slave (
        input  sw_in,
        input  hold,
        output x_out,
        output x_changed,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/g1_input_debounce.sv
//----------------------------------------------------------------------------
// Module  : g1_input_debounce
// Brief   : Four independent switch debouncers behind a two-flop synchronizer.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module g1_input_debounce #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    g1_input_debounce_if.slave     dbus
);

    localparam int unsigned         CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    C_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       x_out_q, x_out_d;
    logic             x_changed_q, x_changed_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       w_load;
    logic             w_busy;

    always_comb begin
        sync1_d  = dbus.sw_in;
        sync2_d  = sync1_q;
        x_out_d  = x_out_q;
        w_load   = '0;
        for (int i = 0; i < 4; i++) begin
            // any match, or hold, discards the run in progress
            cnt_d[i] = '0;
            if (!dbus.hold && (sync2_q[i] != x_out_q[i])) begin
                if (cnt_q[i] >= C_LAST) begin
                    w_load[i]  = 1'b1;
                    x_out_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        x_changed_d = |w_load;
    end

    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_busy = w_busy | (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            x_out_q     <= '0;
            x_changed_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            x_out_q     <= x_out_d;
            x_changed_q <= x_changed_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign dbus.x_out     = x_out_q;
    assign dbus.x_changed = x_changed_q;
    assign dbus.busy      = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_g1_input_debounce.sv
//----------------------------------------------------------------------------
// Module  : tb_g1_input_debounce
// Brief   : Directed bench for g1_input_debounce with STABLE_CYCLES = 4.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_g1_input_debounce;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    g1_input_debounce_if dif ();

    g1_input_debounce #(.STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbus  (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, land 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // input already changed before the coming edge 0: value appears after edge 5
    task automatic run_update(input string tag, input logic [3:0] old_v, input logic [3:0] new_v);
        for (int e = 0; e < 5; e++) begin
            step();
            chk({tag, "_x_hold"}, 32'(dif.x_out), 32'(old_v));
            chk({tag, "_chg_lo"}, 32'(dif.x_changed), 32'd0);
        end
        step();
        chk({tag, "_x_new"}, 32'(dif.x_out), 32'(new_v));
        chk({tag, "_chg_hi"}, 32'(dif.x_changed), 32'd1);
        step();
        chk({tag, "_chg_once"}, 32'(dif.x_changed), 32'd0);
        chk({tag, "_x_keep"}, 32'(dif.x_out), 32'(new_v));
    endtask

    task automatic settle(input string tag, input logic [3:0] v);
        repeat (8) step();
        chk({tag, "_x"}, 32'(dif.x_out), 32'(v));
        chk({tag, "_busy"}, 32'(dif.busy), 32'd0);
        chk({tag, "_chg"}, 32'(dif.x_changed), 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        dif.sw_in = 4'hF;
        dif.hold  = 1'b0;

        // reset holds everything at zero despite live switches and clock
        #1;
        chk("rst_x_async", 32'(dif.x_out), 32'd0);
        repeat (6) step();
        chk("rst_x", 32'(dif.x_out), 32'd0);
        chk("rst_chg", 32'(dif.x_changed), 32'd0);
        chk("rst_busy", 32'(dif.busy), 32'd0);

        // release before edge 0 with sw_in = F
        rst_n = 1'b1;
        run_update("boot", 4'h0, 4'hF);

        // glitch of 3 cycles on bit 0
        dif.sw_in = 4'h0;
        settle("clr0", 4'h0);
        dif.sw_in = 4'h1;
        repeat (3) step();
        dif.sw_in = 4'h0;
        step();
        chk("glitch_busy", 32'(dif.busy), 32'd1);
        for (int e = 0; e < 6; e++) begin
            step();
            chk("glitch_x", 32'(dif.x_out), 32'd0);
            chk("glitch_chg", 32'(dif.x_changed), 32'd0);
        end
        chk("glitch_busy_end", 32'(dif.busy), 32'd0);

        // bit 0 then bit 3 two cycles later: two separate pulses
        dif.sw_in = 4'h1;
        step();
        step();
        dif.sw_in = 4'h9;
        step();
        step();
        step();
        chk("b0_x_pre", 32'(dif.x_out), 32'd0);
        step();
        chk("b0_x", 32'(dif.x_out), 32'h1);
        chk("b0_chg", 32'(dif.x_changed), 32'd1);
        step();
        chk("b0_x_gap", 32'(dif.x_out), 32'h1);
        chk("b0_chg_gap", 32'(dif.x_changed), 32'd0);
        step();
        chk("b3_x", 32'(dif.x_out), 32'h9);
        chk("b3_chg", 32'(dif.x_changed), 32'd1);
        step();
        chk("b3_chg_once", 32'(dif.x_changed), 32'd0);

        // hold freezes decisions for 10 cycles
        dif.sw_in = 4'h0;
        settle("clr1", 4'h0);
        dif.hold  = 1'b1;
        dif.sw_in = 4'h6;
        for (int e = 0; e < 10; e++) begin
            step();
            chk("hold_x", 32'(dif.x_out), 32'd0);
            chk("hold_busy", 32'(dif.busy), 32'd0);
            chk("hold_chg", 32'(dif.x_changed), 32'd0);
        end
        dif.hold = 1'b0;
        step();
        chk("unhold_busy", 32'(dif.busy), 32'd1);
        chk("unhold_x_n", 32'(dif.x_out), 32'd0);
        step();
        step();
        chk("unhold_x_n2", 32'(dif.x_out), 32'd0);
        step();
        chk("unhold_x", 32'(dif.x_out), 32'h6);
        chk("unhold_chg", 32'(dif.x_changed), 32'd1);
        step();
        chk("unhold_chg_once", 32'(dif.x_changed), 32'd0);

        // bit 2 run reaches count 2, then reset pulse between edges
        dif.sw_in = 4'h2;
        repeat (4) step();
        chk("mid_busy", 32'(dif.busy), 32'd1);
        chk("mid_x", 32'(dif.x_out), 32'h6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_x", 32'(dif.x_out), 32'd0);
        chk("mrst_busy", 32'(dif.busy), 32'd0);
        chk("mrst_chg", 32'(dif.x_changed), 32'd0);
        #1;
        rst_n = 1'b1;
        run_update("mrst", 4'h0, 4'h2);

        // all four bits rise together
        dif.sw_in = 4'h0;
        settle("clr2", 4'h0);
        dif.sw_in = 4'hF;
        run_update("all", 4'h0, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
